// File: rtl/serial_sum_collector.sv
// serial_sum_collector
// Collects two LSB-first operand bit streams from the upstream parallel-to-serial
// shifter. It adds them one bit at a time with a full adder and a carry flop, and
// assembles the WIDTH-bit sum in a shift register. The finished sum and its carry-out
// are offered to the result consumer on a valid/ready handshake.

module serial_sum_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             a_bit_i,
    input  logic             b_bit_i,
    input  logic             sum_ready_i,
    output logic             busy_o,
    output logic             sum_valid_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    // The bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
    localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_sr;
    logic             carry_out;
    logic             busy_q;
    logic             valid_q;

    logic             fa_sum;
    logic             fa_carry;
    logic             accept_bit;
    logic             last_bit;

    // One-bit full adder on the current operand bits and the running carry.
    // It also decodes whether this cycle consumes a bit, and whether that bit is the MSB.
    always_comb begin
        fa_sum     = a_bit_i ^ b_bit_i ^ carry;
        fa_carry   = (a_bit_i & b_bit_i) | (a_bit_i & carry) | (b_bit_i & carry);
        accept_bit = (state == ADD) && bit_valid_i;
        last_bit   = accept_bit && (cnt == LAST_CNT);
    end

    // Control FSM and datapath registers.
    // The busy and valid flags are loaded with the decode of the next state. They
    // therefore always equal the current state decode and come straight off flops.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            carry     <= 1'b0;
            cnt       <= '0;
            sum_sr    <= '0;
            carry_out <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= ADD;
                        busy_q    <= 1'b1;
                        valid_q   <= 1'b0;
                        carry     <= 1'b0;
                        cnt       <= '0;
                        sum_sr    <= '0;
                        carry_out <= 1'b0;
                    end
                end

                ADD: begin
                    if (accept_bit) begin
                        sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                        carry  <= fa_carry;
                        if (last_bit) begin
                            state     <= HOLD;
                            busy_q    <= 1'b0;
                            valid_q   <= 1'b1;
                            carry_out <= fa_carry;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end

                HOLD: begin
                    if (sum_ready_i) begin
                        valid_q <= 1'b0;
                        if (start_i) begin
                            state     <= ADD;
                            busy_q    <= 1'b1;
                            carry     <= 1'b0;
                            cnt       <= '0;
                            sum_sr    <= '0;
                            carry_out <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are driven directly from registers.
    // sum_o keeps the last result through IDLE until the next start clears it.
    always_comb begin
        busy_o      = busy_q;
        sum_valid_o = valid_q;
        sum_o       = sum_sr;
        carry_o     = carry_out;
    end

endmodule
